// File: rtl/l1_cache_pkg.sv
// cache_types: shared state encoding and line geometry for the L1 cache.
// Contents: state_t FSM enum, OFFSET_W (byte offset bits), LINE_W (line bits),
//           WORDS_PER_LINE (32-bit words per line).
package cache_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam int OFFSET_W       = 5;
  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = LINE_W / 32;

endpackage

// File: rtl/l1_cache_array.sv
// l1_cache_array: DEPTH x WIDTH storage, asynchronous read, synchronous write
// with one enable bit per byte lane. CLEAR=1 adds an async clear on rst.
// Ports: clk, rst, we_i/be_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module l1_cache_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter bit CLEAR = 1'b0,
  parameter int AW    = $clog2(DEPTH),
  parameter int BE_W  = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [BE_W-1:0]  be_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] merged_d;

  // Expand byte enables to a bit mask; a trailing partial byte follows the
  // enable of the byte lane it sits in.
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_mask[i] = be_i[i / 8];
    end
    merged_d = (mem_q[waddr_i] & ~bit_mask) | (wdata_i & bit_mask);
  end

  assign rdata_o = mem_q[raddr_i];

  generate
    if (CLEAR) begin : g_clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
          end
        end else if (we_i) begin
          mem_q[waddr_i] <= merged_d;
        end
      end
    end else begin : g_noclear
      logic unused_rst;
      assign unused_rst = rst;
      always_ff @(posedge clk) begin
        if (we_i) begin
          mem_q[waddr_i] <= merged_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/l1_cache.sv
// l1_cache: direct-mapped, write-back, write-allocate cache between a word
// port (mem_*) and a 256-bit line memory (pmem_*). Hits answer one cycle after
// the request; misses write back a dirty victim, then fill, then re-check.
// Ports: clk, rst; core side mem_read/mem_write/mem_byte_enable/mem_address/
// mem_wdata -> mem_resp/mem_rdata; memory side pmem_read/pmem_write/
// pmem_address/pmem_wdata <- pmem_resp/pmem_rdata.
module l1_cache
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    mem_byte_enable,
  input  logic [31:0]   mem_address,
  input  logic [31:0]   mem_wdata,
  output logic          mem_resp,
  output logic [31:0]   mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [31:0]   pmem_address,
  output logic [255:0]  pmem_wdata,
  input  logic          pmem_resp,
  input  logic [255:0]  pmem_rdata
);

  localparam int TAG_W = 32 - OFFSET_W - S_INDEX;
  localparam int SETS  = 2 ** S_INDEX;

  state_t state_q, state_d;

  logic [TAG_W-1:0]   addr_tag;
  logic [S_INDEX-1:0] addr_idx;
  logic [2:0]         addr_word;
  logic [1:0]         unused_addr_lsb;

  assign addr_tag        = mem_address[31:OFFSET_W+S_INDEX];
  assign addr_idx        = mem_address[OFFSET_W+S_INDEX-1:OFFSET_W];
  assign addr_word       = mem_address[4:2];
  assign unused_addr_lsb = mem_address[1:0];

  logic [LINE_W-1:0] line_rd;
  logic [TAG_W-1:0]  tag_rd;
  logic              valid_rd;
  logic              dirty_rd;

  logic req, hit, fill, wr_hit;
  logic [31:0]       data_be;
  logic [LINE_W-1:0] data_wdata;
  logic [31:0]       hit_word;

  assign req    = mem_read | mem_write;
  assign hit    = valid_rd && (tag_rd == addr_tag);
  assign fill   = (state_q == ALLOCATE) && pmem_resp;
  // A simultaneous read+write request is a write.
  assign wr_hit = (state_q == CHECK) && req && hit && mem_write;

  // Fill writes the whole line; a write hit touches only its word's lanes.
  assign data_be    = fill ? '1 : (32'(mem_byte_enable) << {addr_word, 2'b00});
  assign data_wdata = fill ? pmem_rdata : {WORDS_PER_LINE{mem_wdata}};
  assign hit_word   = line_rd[{addr_word, 5'b00000} +: 32];

  l1_cache_array #(.WIDTH(LINE_W), .DEPTH(SETS), .CLEAR(1'b0)) u_data (
    .clk(clk), .rst(rst),
    .we_i(fill | wr_hit), .be_i(data_be), .waddr_i(addr_idx), .wdata_i(data_wdata),
    .raddr_i(addr_idx), .rdata_o(line_rd)
  );

  l1_cache_array #(.WIDTH(TAG_W), .DEPTH(SETS), .CLEAR(1'b0)) u_tag (
    .clk(clk), .rst(rst),
    .we_i(fill), .be_i('1), .waddr_i(addr_idx), .wdata_i(addr_tag),
    .raddr_i(addr_idx), .rdata_o(tag_rd)
  );

  l1_cache_array #(.WIDTH(1), .DEPTH(SETS), .CLEAR(1'b1)) u_valid (
    .clk(clk), .rst(rst),
    .we_i(fill), .be_i(1'b1), .waddr_i(addr_idx), .wdata_i(1'b1),
    .raddr_i(addr_idx), .rdata_o(valid_rd)
  );

  // Fill clears dirty; a write hit with at least one enabled byte sets it.
  // A write hit with no enabled bytes leaves dirty untouched.
  l1_cache_array #(.WIDTH(1), .DEPTH(SETS), .CLEAR(1'b1)) u_dirty (
    .clk(clk), .rst(rst),
    .we_i(fill | (wr_hit && (mem_byte_enable != 4'b0000))), .be_i(1'b1),
    .waddr_i(addr_idx), .wdata_i(!fill),
    .raddr_i(addr_idx), .rdata_o(dirty_rd)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A miss, once started, runs to completion even if the
  // core withdraws the request; CHECK then falls back to IDLE silently.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = CHECK;
      end
      CHECK: begin
        if (!req || hit)           state_d = IDLE;
        else if (valid_rd && dirty_rd) state_d = WRITEBACK;
        else                       state_d = ALLOCATE;
      end
      WRITEBACK: begin
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (pmem_resp) state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: data/address buses are zero outside the state that owns them.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      CHECK: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          if (mem_read && !mem_write) mem_rdata = hit_word;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_rd, addr_idx, 5'b00000};
        pmem_wdata   = line_rd;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:5], 5'b00000};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: randomized + directed bench for l1_cache with a reference cache
// model, a pmem responder checking line traffic, and a response monitor.
// Ports: none (top-level bench).
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  l1_cache #(.S_INDEX(3)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {logic is_read; logic [31:0] rdata;} resp_t;
  typedef struct {logic is_write; logic [31:0] addr; logic [255:0] data;} pev_t;

  resp_t exp_resp_q[$];
  pev_t  exp_pmem_q[$];

  // Backing memory seen by the responder, and the model's own view of memory.
  logic [255:0] env_mem [int unsigned];
  logic [255:0] ref_mem [int unsigned];

  // Reference cache: 8 sets, direct mapped.
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [23:0]  m_tag   [8];
  logic [255:0] m_line  [8];

  function automatic logic [255:0] default_line(input logic [26:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la[15:0], 13'h0, 3'(i)} ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [255:0] env_get(input logic [26:0] la);
    if (env_mem.exists(int'(la))) return env_mem[int'(la)];
    return default_line(la);
  endfunction

  function automatic logic [255:0] ref_get(input logic [26:0] la);
    if (ref_mem.exists(int'(la))) return ref_mem[int'(la)];
    return default_line(la);
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Predict pmem traffic and the core response for one access.
  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input bit expect_resp, output bit was_hit);
    int unsigned  set;
    logic [23:0]  tag;
    logic [26:0]  la;
    int unsigned  w;
    pev_t         ev;
    resp_t        r;
    set = addr[7:5];
    tag = addr[31:8];
    la  = addr[31:5];
    w   = addr[4:2];
    was_hit = m_valid[set] && (m_tag[set] == tag);
    if (!was_hit) begin
      if (m_valid[set] && m_dirty[set]) begin
        ev.is_write = 1'b1;
        ev.addr = {m_tag[set], 3'(set), 5'b0};
        ev.data = m_line[set];
        exp_pmem_q.push_back(ev);
        ref_mem[int'({m_tag[set], 3'(set)})] = m_line[set];
      end
      ev.is_write = 1'b0;
      ev.addr = {la, 5'b0};
      ev.data = ref_get(la);
      exp_pmem_q.push_back(ev);
      m_line[set]  = ref_get(la);
      m_valid[set] = 1'b1;
      m_dirty[set] = 1'b0;
      m_tag[set]   = tag;
    end
    if (expect_resp) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_line[set][w*32 + b*8 +: 8] = wd[b*8 +: 8];
        if (be != 4'b0) m_dirty[set] = 1'b1;
        r.is_read = 1'b0;
        r.rdata = '0;
      end else begin
        r.is_read = 1'b1;
        r.rdata = m_line[set][w*32 +: 32];
      end
      exp_resp_q.push_back(r);
    end
  endtask

  // Issue one request (at posedge+1), wait for its response, drop it.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, output logic [31:0] rdata);
    bit hit;
    int lat;
    model_access(wr, addr, wd, be, 1'b1, hit);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    lat = 0;
    rdata = '0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mem_resp) begin
        rdata = mem_rdata;
        break;
      end
      if (lat > 300) begin
        failures++;
        $display("FAIL resp_timeout addr=%h waited=%0d cycles", addr, lat);
        break;
      end
    end
    checks++;
    if (hit && lat != 1) begin
      failures++;
      $display("FAIL hit_latency addr=%h got=%0d want=1", addr, lat);
    end else if (!hit && lat < 3) begin
      failures++;
      $display("FAIL miss_latency addr=%h got=%0d want>=3", addr, lat);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // pmem responder: random latency, checks each completed transaction.
  initial begin
    int cnt, target;
    pev_t e;
    cnt = 0; target = 2;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (rst) begin
        cnt = 0;
        continue;
      end
      if (pmem_read || pmem_write) begin
        if (cnt == 0) target = $urandom_range(2, 5);
        cnt++;
        if (cnt >= target) begin
          cnt = 0;
          checks++;
          if (exp_pmem_q.size() == 0) begin
            failures++;
            $display("FAIL pmem_unexpected rd=%0b wr=%0b addr=%h want=none",
                     pmem_read, pmem_write, pmem_address);
          end else begin
            e = exp_pmem_q.pop_front();
            if (e.is_write !== pmem_write || e.addr !== pmem_address ||
                (e.is_write && e.data !== pmem_wdata)) begin
              failures++;
              $display("FAIL pmem_txn got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                       pmem_write, pmem_address, pmem_wdata, e.is_write, e.addr, e.data);
            end
          end
          if (pmem_write) env_mem[int'(pmem_address[31:5])] = pmem_wdata;
          else pmem_rdata = env_get(pmem_address[31:5]);
          pmem_resp = 1'b1;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        checks++;
        if (pmem_read && pmem_write) begin
          failures++;
          $display("FAIL pmem_both got rd=1 wr=1 want one of them");
        end
      end
      if (mem_resp) begin
        checks++;
        if (exp_resp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected addr=%h got resp=1 want none", mem_address);
        end else begin
          r = exp_resp_q.pop_front();
          if (r.is_read && mem_rdata !== r.rdata) begin
            failures++;
            $display("FAIL rdata addr=%h got=%h want=%h", mem_address, mem_rdata, r.rdata);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rd;
    logic [255:0] pre;
    bit           dummy;
    int           n;

    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
    mem_address = '0; mem_wdata = '0;
    model_reset();

    pre = default_line(27'h2);
    pre[1*32 +: 32] = 32'hAABB_CCDD;
    pre[2*32 +: 32] = 32'hDEAD_BEEF;
    env_mem[2] = pre;
    ref_mem[2] = pre;

    #1;
    check("reset_mem_resp",     256'(mem_resp),     256'(0));
    check("reset_mem_rdata",    256'(mem_rdata),    256'(0));
    check("reset_pmem_read",    256'(pmem_read),    256'(0));
    check("reset_pmem_write",   256'(pmem_write),   256'(0));
    check("reset_pmem_address", 256'(pmem_address), 256'(0));
    check("reset_pmem_wdata",   pmem_wdata,         256'(0));

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Fill then hit.
    do_req(1, 0, 32'h40, 32'h0, 4'h0, rd);
    do_req(1, 0, 32'h48, 32'h0, 4'h0, rd);
    check("hit_word2", 256'(rd), 256'(32'hDEAD_BEEF));

    // Partial write on resident line.
    do_req(0, 1, 32'h44, 32'h1122_3344, 4'b0011, rd);
    do_req(1, 0, 32'h44, 32'h0, 4'h0, rd);
    check("byte_merge", 256'(rd), 256'(32'hAABB_3344));

    // Dirty eviction, then clean conflict misses.
    do_req(1, 0, 32'h140, 32'h0, 4'h0, rd);
    do_req(1, 0, 32'h40, 32'h0, 4'h0, rd);
    do_req(1, 0, 32'h44, 32'h0, 4'h0, rd);
    check("after_writeback", 256'(rd), 256'(32'hAABB_3344));
    do_req(1, 0, 32'h140, 32'h0, 4'h0, rd);

    // Core drops its read during ALLOCATE.
    model_access(1'b0, 32'h1040, 32'h0, 4'h0, 1'b0, dummy);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h1040;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (pmem_read) break;
      if (n > 50) begin
        failures++;
        $display("FAIL drop_wait_alloc got=no pmem_read want=pmem_read");
        break;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("drop_fill_done", 256'(exp_pmem_q.size()), 256'(0));
    do_req(1, 0, 32'h1040, 32'h0, 4'h0, rd);

    // Reset during WRITEBACK.
    do_req(0, 1, 32'h44, 32'hFFFF_FFFF, 4'hF, rd);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h140;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (pmem_write) break;
      if (n > 50) begin
        failures++;
        $display("FAIL rst_wait_wb got=no pmem_write want=pmem_write");
        break;
      end
    end
    check("wb_address", 256'(pmem_address), 256'(32'h40));
    check("wb_data", pmem_wdata, m_line[2]);
    rst = 1'b1;
    #1;
    check("rst_wb_pmem_write", 256'(pmem_write),   256'(0));
    check("rst_wb_pmem_read",  256'(pmem_read),    256'(0));
    check("rst_wb_address",    256'(pmem_address), 256'(0));
    check("rst_wb_mem_resp",   256'(mem_resp),     256'(0));
    mem_read = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_req(1, 0, 32'h44, 32'h0, 4'h0, rd);
    check("post_rst_read", 256'(rd), 256'(32'hAABB_3344));

    // Random traffic over a few conflicting tags.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int op;
      a = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 2'b00};
      op = $urandom_range(0, 3);
      case (op)
        0, 1: do_req(1, 0, a, 32'h0, 4'h0, rd);
        2:    do_req(0, 1, a, $urandom, 4'($urandom), rd);
        default: do_req(1, 1, a, $urandom, 4'($urandom), rd);
      endcase
    end

    repeat (3) @(posedge clk);
    check("resp_queue_empty", 256'(exp_resp_q.size()), 256'(0));
    check("pmem_queue_empty", 256'(exp_pmem_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
